// File: rtl/pipe_pkg.sv
// Shared state encoding and occupancy helpers for the pipeline register slice.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Number of held entries for a given state; 3 is unreachable.
    function automatic logic [OCC_W-1:0] occ_of(input state_e s);
        case (s)
            ST_HALF: occ_of = OCC_W'(1);
            ST_FULL: occ_of = OCC_W'(2);
            default: occ_of = OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/slice_entry.sv
// Load-enabled flag+payload register used as the main and skid entries.
module slice_entry #(
    parameter int unsigned WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [WIDTH:0] d,
    output logic [WIDTH:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_slice.sv
// Valid/ready register slice with a two-entry skid buffer; in_ready and out_* come
// straight from flops so neither handshake path is combinational through the slice.
module pipe_reg_slice
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_flag,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_e         state;
    state_e         next_state;
    logic           accept;
    logic           drain;
    logic           main_load;
    logic           skid_load;
    logic           main_from_skid;
    logic [WIDTH:0] in_word;
    logic [WIDTH:0] main_d;
    logic [WIDTH:0] main_q;
    logic [WIDTH:0] skid_q;

    assign accept  = in_valid & in_ready;
    assign drain   = out_valid & out_ready;
    assign in_word = {in_flag, in_data};
    assign main_d  = main_from_skid ? skid_q : in_word;

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != ST_FULL);
            out_valid <= (next_state != ST_EMPTY);
            occupancy <= occ_of(next_state);
        end
    end

    // Next state and entry load enables; flush voids any handshake this cycle.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        next_state = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load  = 1'b1;
                        next_state = ST_FULL;
                    end else if (drain) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        next_state     = ST_HALF;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    slice_entry #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    slice_entry #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_word),
        .q    (skid_q)
    );

    assign out_flag = main_q[WIDTH];
    assign out_data = main_q[WIDTH-1:0];

endmodule

// File: tb/tb_pipe_reg_slice.sv
// Directed self-checking bench for pipe_reg_slice at WIDTH=2 and WIDTH=8.
module tb_pipe_reg_slice;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       in_flag;
    logic [1:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_flag;
    logic [1:0] out_data;
    logic [1:0] occupancy;

    logic       w_in_valid;
    logic       w_in_ready;
    logic       w_in_flag;
    logic [7:0] w_in_data;
    logic       w_out_valid;
    logic       w_out_ready;
    logic       w_out_flag;
    logic [7:0] w_out_data;
    logic [1:0] w_occupancy;

    int n_checks;
    int n_fail;

    pipe_reg_slice #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flag   (in_flag),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flag  (out_flag),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_reg_slice #(.WIDTH(8)) dut_w8 (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_flag   (w_in_flag),
        .in_data   (w_in_data),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_flag  (w_out_flag),
        .out_data  (w_out_data),
        .occupancy (w_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land just after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [1:0] d);
        in_valid = v;
        in_flag  = f;
        in_data  = d;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        drive(1'b1, 1'b1, 2'b11);
        w_in_valid  = 1'b0;
        w_in_flag   = 1'b0;
        w_in_data   = 8'h00;
        w_out_ready = 1'b0;

        // Reset held for two edges while upstream offers a word.
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_flag",  32'(out_flag),  32'd0);
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        rst = 1'b1;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_word",  32'({out_flag, out_data}), 32'h7);
        check("first_occ",   32'(occupancy), 32'd1);
        drive(1'b0, 1'b0, 2'b00);
        out_ready = 1'b1;
        tick();
        check("first_drain_occ", 32'(occupancy), 32'd0);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ~1'(i), 2'(i));
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_word",  32'({out_flag, out_data}), 32'({~1'(i), 2'(i)}));
            check("stream_occ",   32'(occupancy), 32'd1);
        end
        drive(1'b0, 1'b0, 2'b00);
        tick();
        check("stream_end_occ", 32'(occupancy), 32'd0);

        // Backpressure fills the skid entry and holds off a third word.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 2'd1);
        tick();
        check("bp_half_occ", 32'(occupancy), 32'd1);
        drive(1'b1, 1'b0, 2'd2);
        tick();
        check("bp_full_occ",   32'(occupancy), 32'd2);
        check("bp_full_ready", 32'(in_ready),  32'd0);
        check("bp_full_word",  32'({out_flag, out_data}), 32'h5);
        drive(1'b1, 1'b1, 2'd3);
        tick();
        check("bp_hold_occ",  32'(occupancy), 32'd2);
        check("bp_hold_word", 32'({out_flag, out_data}), 32'h5);
        out_ready = 1'b1;
        tick();
        check("bp_drain1_word",  32'({out_flag, out_data}), 32'h2);
        check("bp_drain1_occ",   32'(occupancy), 32'd1);
        check("bp_drain1_ready", 32'(in_ready),  32'd1);
        tick();
        check("bp_drain2_word", 32'({out_flag, out_data}), 32'h7);
        check("bp_drain2_occ",  32'(occupancy), 32'd1);
        drive(1'b0, 1'b0, 2'b00);
        tick();
        check("bp_end_valid", 32'(out_valid), 32'd0);

        // Simultaneous accept and drain in HALF.
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd1);
        tick();
        check("sim_main_word", 32'({out_flag, out_data}), 32'h1);
        drive(1'b1, 1'b1, 2'd3);
        out_ready = 1'b1;
        tick();
        check("sim_word", 32'({out_flag, out_data}), 32'h7);
        check("sim_occ",  32'(occupancy), 32'd1);
        drive(1'b0, 1'b0, 2'b00);
        tick();
        check("sim_end_occ", 32'(occupancy), 32'd0);

        // Flush in FULL voids the word offered in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 2'd1);
        tick();
        drive(1'b1, 1'b0, 2'd3);
        tick();
        check("fl_full_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 1'b0, 2'd2);
        flush = 1'b1;
        tick();
        check("fl_valid",    32'(out_valid), 32'd0);
        check("fl_occ",      32'(occupancy), 32'd0);
        check("fl_ready",    32'(in_ready),  32'd1);
        check("fl_payload",  32'({out_flag, out_data}), 32'h5);
        flush = 1'b0;
        drive(1'b0, 1'b0, 2'b00);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_ghost", 32'(out_valid), 32'd0);
        end

        // Reset while FULL discards everything.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 2'd2);
        tick();
        drive(1'b1, 1'b1, 2'd3);
        tick();
        check("mr_full_occ", 32'(occupancy), 32'd2);
        rst = 1'b0;
        tick();
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_occ",   32'(occupancy), 32'd0);
        check("mr_ready", 32'(in_ready),  32'd1);
        check("mr_word",  32'({out_flag, out_data}), 32'h0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'b00);
        tick();
        check("mr_after_valid", 32'(out_valid), 32'd0);

        // WIDTH=8: fill both entries then drain in order.
        w_in_valid = 1'b1;
        w_in_flag  = 1'b0;
        w_in_data  = 8'hA5;
        tick();
        w_in_flag  = 1'b1;
        w_in_data  = 8'h5A;
        tick();
        check("w8_full_occ",  32'(w_occupancy), 32'd2);
        check("w8_full_word", 32'({w_out_flag, w_out_data}), 32'h0A5);
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        tick();
        check("w8_drain_word", 32'({w_out_flag, w_out_data}), 32'h15A);
        check("w8_drain_occ",  32'(w_occupancy), 32'd1);
        tick();
        check("w8_end_valid", 32'(w_out_valid), 32'd0);
        check("w8_end_occ",   32'(w_occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
